// File: rtl/instruction_decoder.sv
// Instruction decoder: turns each 8-bit program word into sequencer/datapath strobes,
// and owns the zero flag, the reset synchroniser and the debug instruction register.
module instruction_decoder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] NOP_OPCODE  = 8'hC8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] pm_data,
    input  logic       alu_zero,
    output logic       sync_reset,
    output logic       jmp,
    output logic       jmp_nz,
    output logic [3:0] jmp_addr,
    output logic       dont_jmp,
    output logic       load_instr,
    output logic       NOPC8,
    output logic [8:0] reg_en,
    output logic [3:0] src_sel,
    output logic       x_sel,
    output logic       y_sel,
    output logic [2:0] alu_func,
    output logic [7:0] ir
);

    logic [SYNC_STAGES-1:0] sync_chain_r;
    logic                   flag_r;
    logic [7:0]             ir_r;

    logic       jmp_s;
    logic       jmp_nz_s;
    logic       load_s;
    logic       nop_s;
    logic       alu_s;
    logic [8:0] reg_en_s;
    logic [3:0] src_sel_s;
    logic       x_sel_s;
    logic       y_sel_s;
    logic [2:0] alu_func_s;

    // Reset synchroniser: asserts asynchronously, releases after SYNC_STAGES edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_chain_r <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_chain_r[0] <= 1'b0;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_chain_r[i] <= sync_chain_r[i-1];
            end
        end
    end

    assign sync_reset = sync_chain_r[SYNC_STAGES-1];

    // Raw instruction-class decode; the NOP word is checked first so it masks the ALU class.
    always_comb begin
        jmp_s      = 1'b0;
        jmp_nz_s   = 1'b0;
        load_s     = 1'b0;
        nop_s      = 1'b0;
        alu_s      = 1'b0;
        reg_en_s   = 9'h000;
        src_sel_s  = 4'h0;
        x_sel_s    = 1'b0;
        y_sel_s    = 1'b0;
        alu_func_s = 3'h0;
        if (pm_data == NOP_OPCODE) begin
            nop_s = 1'b1;
        end else begin
            case (pm_data[7:6])
                2'b00, 2'b01: begin
                    load_s    = 1'b1;
                    reg_en_s  = 9'h001 << pm_data[6:4];
                    src_sel_s = 4'h8;
                end
                2'b10: begin
                    reg_en_s  = 9'h001 << pm_data[5:3];
                    src_sel_s = {1'b0, pm_data[2:0]};
                end
                2'b11: begin
                    if (!pm_data[5]) begin
                        alu_s      = 1'b1;
                        reg_en_s   = 9'h100;
                        x_sel_s    = pm_data[4];
                        y_sel_s    = pm_data[3];
                        alu_func_s = pm_data[2:0];
                    end else if (pm_data[4]) begin
                        jmp_nz_s = 1'b1;
                    end else begin
                        jmp_s = 1'b1;
                    end
                end
                default: begin
                    reg_en_s = 9'h000;
                end
            endcase
        end
    end

    // Output gating: every decode strobe is forced low while the sequencer is held in reset.
    always_comb begin
        jmp        = 1'b0;
        jmp_nz     = 1'b0;
        jmp_addr   = 4'h0;
        load_instr = 1'b0;
        NOPC8      = 1'b0;
        reg_en     = 9'h000;
        src_sel    = 4'h0;
        x_sel      = 1'b0;
        y_sel      = 1'b0;
        alu_func   = 3'h0;
        if (sync_reset) begin
            reg_en = 9'h000;
        end else begin
            jmp        = jmp_s;
            jmp_nz     = jmp_nz_s;
            jmp_addr   = pm_data[3:0];
            load_instr = load_s;
            NOPC8      = nop_s;
            reg_en     = reg_en_s;
            src_sel    = src_sel_s;
            x_sel      = x_sel_s;
            y_sel      = y_sel_s;
            alu_func   = alu_func_s;
        end
    end

    // Zero flag: captured only on a real ALU instruction outside reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flag_r <= 1'b0;
        end else if (!sync_reset && alu_s) begin
            flag_r <= alu_zero;
        end else begin
            flag_r <= flag_r;
        end
    end

    // Debug copy of the instruction word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_r <= 8'h00;
        end else if (sync_reset) begin
            ir_r <= 8'h00;
        end else begin
            ir_r <= pm_data;
        end
    end

    assign dont_jmp = flag_r;
    assign ir       = ir_r;

endmodule
